obj_dma: RTL and testbench
==========================

// Module: obj_dma
// PURPOSE
//   Object-memory DMA engine on the CPU side of top. A CPU write to DMA_REG_ADDR
//   latches a source RAM page. At the next vertical blank the engine stalls the
//   CPU, takes the bus, and copies LEN bytes from {page,idx} in RAM to
//   DST_BASE+idx in object memory (0x4800 region).
//   Its bus outputs are muxed onto cpu_address/data_in/wen_n/ram_OE_B ahead of top.
// PARAMETERS
//   DMA_REG_ADDR  16'h4F00  CPU-visible trigger register address (write-only)
//   DST_BASE      16'h4800  first object-memory destination address
//   LEN           256       bytes per transfer, legal range 1..256
// PORTS
//   clk_1          in   1   CPU-domain clock, all state on posedge
//   rst_n          in   1   asynchronous, active-low reset
//   cpu_address    in   16  CPU address, snooped for trigger
//   cpu_data_in    in   8   CPU write data, snooped for trigger
//   cpu_wen_n      in   1   CPU write enable, active low
//   vblank         in   1   high during vertical blank (GPU timing)
//   ram_data_in    in   8   RAM read data, valid in READ cycle
//   cpu_rdy        out  1   low = CPU stalled
//   dma_owns_bus   out  1   high = bus mux selects dma_* signals
//   dma_address    out  16  DMA bus address
//   dma_data_out   out  8   DMA write data
//   dma_wen_n      out  1   DMA write enable, active low
//   dma_ram_oe_n   out  1   RAM output enable, active low
//   dma_busy       out  1   high in ARMED/READ/WRITE/DONE
//   dma_done       out  1   one-cycle pulse at transfer end
//   dma_overrun    out  1   sticky; vblank fell before transfer completed
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, idx=0, page=0, overrun=0.
//     Outputs: cpu_rdy=1, dma_owns_bus=0, dma_wen_n=1, dma_ram_oe_n=1,
//     dma_address=0, dma_data_out=0, dma_busy=0, dma_done=0.
//   FSM (registered state; outputs decode from state/idx/latch only):
//   - IDLE:  trigger = posedge with cpu_wen_n=0 and cpu_address==DMA_REG_ADDR.
//            On trigger: page<=cpu_data_in, overrun<=0, idx<=0, go ARMED.
//   - ARMED: cpu_rdy=0, bus not owned. When vblank=1, go READ next edge.
//            If vblank is already 1, READ is entered 2 cycles after the trigger edge.
//   - READ:  owns_bus=1, address={page,idx}, ram_oe_n=0. ram_data_in latched
//            at the exiting edge. Go WRITE.
//   - WRITE: owns_bus=1, address=DST_BASE+idx (16-bit wrap), data_out=latch,
//            wen_n=0. If idx==LEN-1 go DONE, else idx++ and go READ.
//   - DONE:  one cycle. done=1, cpu_rdy=0, bus released. Go IDLE, where cpu_rdy=1.
//   Bus ownership runs 2*LEN cycles. Total stall = 1 (ARMED min) + 2*LEN + 1.
//   Triggers in any state other than IDLE are ignored: page and idx unchanged.
//   vblank falling in READ/WRITE: the transfer completes anyway and overrun<=1.
//     overrun holds until the next accepted trigger.
//   vblank falling in ARMED: stay ARMED and wait for the next vblank.
//   idx is 8 bits; LEN=256 terminates at idx==8'hFF, with no wrap to 0 mid-transfer.
//   rst_n low mid-transfer: immediate IDLE and all outputs at reset values.
//     A partial copy is left in object memory.
// TESTING
//   Reset:    rst_n=0 -> cpu_rdy=1, owns_bus=0, wen_n=1, ram_oe_n=1, busy=0.
//   Transfer: vblank=1, write 0x02 to 0x4F00, RAM[0x02nn]=nn^8'hA5.
//             -> first READ addr 0x0200.
//             -> 256 writes to 0x4800..0x48FF with matching data.
//             -> done pulse 514 cycles after the trigger edge, then cpu_rdy=1.
//   Armed wait: trigger with vblank=0 -> busy=1, cpu_rdy=0, owns_bus=0 for 100
//               cycles; raise vblank -> READ at 0x0200 next edge.
//   Re-trigger: write 0x05 mid-transfer -> ignored, source addresses stay 0x02nn.
//   Overrun:    drop vblank at byte 10 -> all 256 bytes still written, overrun=1;
//               next trigger clears overrun.
//   Reset mid-op: rst_n=0 at byte 40 -> outputs at reset values in the same cycle,
//                 no write >= 0x4828 after release.

Source files
------------

// File: rtl/obj_dma.sv
// Object-memory DMA engine: a CPU write to the trigger register latches a
// source RAM page; at the next vertical blank the engine stalls the CPU,
// takes the bus and copies LEN bytes from {page,idx} to DST_BASE+idx.
// Bus outputs are a pure decode of registered state, so an asynchronous
// reset returns every output to its idle value immediately.
module obj_dma #(
  parameter logic [15:0] DMA_REG_ADDR = 16'h4F00,
  parameter logic [15:0] DST_BASE     = 16'h4800,
  parameter int unsigned LEN          = 256
) (
  input  logic        clk_1,
  input  logic        rst_n,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_data_in,
  input  logic        cpu_wen_n,
  input  logic        vblank,
  input  logic [7:0]  ram_data_in,
  output logic        cpu_rdy,
  output logic        dma_owns_bus,
  output logic [15:0] dma_address,
  output logic [7:0]  dma_data_out,
  output logic        dma_wen_n,
  output logic        dma_ram_oe_n,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_overrun
);

  localparam int unsigned IDX_W  = 8;
  localparam int unsigned ADDR_W = 16;
  // Last byte index; LEN=256 ends at 8'hFF so idx never wraps mid-transfer.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_READ  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [7:0]       page_q,  page_d;
  logic [7:0]       data_q,  data_d;
  logic             overrun_q, overrun_d;

  logic             trigger_c;

  // CPU write to the trigger register, snooped from the CPU bus.
  assign trigger_c = !cpu_wen_n && (cpu_address == DMA_REG_ADDR);

  // State and datapath registers.
  always_ff @(posedge clk_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      page_q    <= '0;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      page_q    <= page_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state and datapath update; triggers outside IDLE are ignored.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    page_d    = page_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    unique case (state_q)
      S_IDLE: begin
        if (trigger_c) begin
          page_d    = cpu_data_in;
          overrun_d = 1'b0;
          idx_d     = '0;
          state_d   = S_ARMED;
        end
      end
      S_ARMED: begin
        // Losing vblank here simply keeps us waiting for the next one.
        if (vblank) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        data_d  = ram_data_in;
        state_d = S_WRITE;
        if (!vblank) begin
          overrun_d = 1'b1;
        end
      end
      S_WRITE: begin
        // The copy always runs to completion; a lost vblank is only flagged.
        if (!vblank) begin
          overrun_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_READ;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from state, index and latched byte.
  always_comb begin
    cpu_rdy      = 1'b1;
    dma_owns_bus = 1'b0;
    dma_address  = '0;
    dma_data_out = '0;
    dma_wen_n    = 1'b1;
    dma_ram_oe_n = 1'b1;
    dma_busy     = 1'b0;
    dma_done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_ARMED: begin
        cpu_rdy  = 1'b0;
        dma_busy = 1'b1;
      end
      S_READ: begin
        cpu_rdy      = 1'b0;
        dma_busy     = 1'b1;
        dma_owns_bus = 1'b1;
        dma_address  = {page_q, idx_q};
        dma_ram_oe_n = 1'b0;
      end
      S_WRITE: begin
        cpu_rdy      = 1'b0;
        dma_busy     = 1'b1;
        dma_owns_bus = 1'b1;
        dma_address  = DST_BASE + ADDR_W'(idx_q);
        dma_data_out = data_q;
        dma_wen_n    = 1'b0;
      end
      S_DONE: begin
        cpu_rdy  = 1'b0;
        dma_busy = 1'b1;
        dma_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign dma_overrun = overrun_q;

endmodule

// File: tb/tb_obj_dma.sv
// Randomized bench for obj_dma: a RAM array feeds reads, object-memory writes
// are collected from the bus and compared with the expected copy and timing.
module tb_obj_dma;

  localparam logic [15:0] REG_ADDR = 16'h4F00;
  localparam logic [15:0] DST      = 16'h4800;
  localparam int          NBYTES   = 256;

  logic        clk_1 = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_data_in;
  logic        cpu_wen_n;
  logic        vblank;
  logic [7:0]  ram_data_in;
  logic        cpu_rdy;
  logic        dma_owns_bus;
  logic [15:0] dma_address;
  logic [7:0]  dma_data_out;
  logic        dma_wen_n;
  logic        dma_ram_oe_n;
  logic        dma_busy;
  logic        dma_done;
  logic        dma_overrun;

  logic [7:0]  ram_mem [0:65535];

  int checks   = 0;
  int failures = 0;

  always #5 clk_1 = ~clk_1;

  // RAM model: drives data only while the engine enables it.
  assign ram_data_in = dma_ram_oe_n ? 8'h5A : ram_mem[dma_address];

  obj_dma dut (
    .clk_1        (clk_1),
    .rst_n        (rst_n),
    .cpu_address  (cpu_address),
    .cpu_data_in  (cpu_data_in),
    .cpu_wen_n    (cpu_wen_n),
    .vblank       (vblank),
    .ram_data_in  (ram_data_in),
    .cpu_rdy      (cpu_rdy),
    .dma_owns_bus (dma_owns_bus),
    .dma_address  (dma_address),
    .dma_data_out (dma_data_out),
    .dma_wen_n    (dma_wen_n),
    .dma_ram_oe_n (dma_ram_oe_n),
    .dma_busy     (dma_busy),
    .dma_done     (dma_done),
    .dma_overrun  (dma_overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_rdy"},   32'(cpu_rdy),      32'd1);
    check_val({tag, "_owns"},  32'(dma_owns_bus), 32'd0);
    check_val({tag, "_wen"},   32'(dma_wen_n),    32'd1);
    check_val({tag, "_oe"},    32'(dma_ram_oe_n), 32'd1);
    check_val({tag, "_busy"},  32'(dma_busy),     32'd0);
    check_val({tag, "_done"},  32'(dma_done),     32'd0);
    check_val({tag, "_addr"},  32'(dma_address),  32'd0);
    check_val({tag, "_data"},  32'(dma_data_out), 32'd0);
  endtask

  // One transfer. Sample k=1 is the first negedge after the trigger edge.
  // armed_wait>0: vblank low at trigger, raised after sample armed_wait.
  // drop_at>=0: vblank drops once that many bytes have been written.
  // retrig_at>0: a write of 0x05 to the trigger register at that sample.
  // reset_at>=0: rst_n pulsed once that many bytes have been written.
  task automatic run_xfer(input logic [7:0] page, input int armed_wait,
                          input int drop_at, input int retrig_at, input int reset_at);
    int nreads, nwr, rd_err, wr_err, ndone, done_k, first_rd, nstall, armed_err;
    int exp_first, post_bad;
    bit finished;
    nreads = 0; nwr = 0; rd_err = 0; wr_err = 0; ndone = 0; done_k = -1;
    first_rd = -1; nstall = 0; armed_err = 0; finished = 1'b0;

    @(negedge clk_1);
    vblank      = (armed_wait == 0);
    cpu_address = REG_ADDR;
    cpu_data_in = page;
    cpu_wen_n   = 1'b0;
    @(posedge clk_1);
    #1;
    cpu_wen_n   = 1'b1;
    cpu_address = 16'h1234;
    cpu_data_in = 8'($urandom);

    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk_1);
      if (k == 1) begin
        check_val("ov_clear_on_trigger", 32'(dma_overrun), 32'd0);
        check_val("busy_after_trigger",  32'(dma_busy),    32'd1);
      end
      if (dma_owns_bus && !dma_ram_oe_n) begin
        if (first_rd < 0) first_rd = k;
        if (dma_address !== {page, 8'(nreads)}) rd_err++;
        nreads++;
      end
      if (dma_owns_bus && !dma_wen_n) begin
        if (dma_address !== DST + 16'(nwr)) wr_err++;
        if (dma_data_out !== ram_mem[{page, 8'(nwr)}]) wr_err++;
        nwr++;
      end
      if (dma_done) begin
        ndone++;
        done_k = k;
      end
      if (!cpu_rdy) nstall++;
      if (armed_wait > 0 && k <= armed_wait) begin
        if (!(dma_busy && !cpu_rdy && !dma_owns_bus)) armed_err++;
      end

      if (armed_wait > 0 && k == armed_wait) vblank = 1'b1;
      if (drop_at >= 0 && nwr == drop_at) vblank = 1'b0;
      if (retrig_at > 0 && k == retrig_at) begin
        cpu_address = REG_ADDR;
        cpu_data_in = 8'h05;
        cpu_wen_n   = 1'b0;
      end
      if (retrig_at > 0 && k == retrig_at + 1) begin
        cpu_wen_n   = 1'b1;
        cpu_address = 16'h1234;
      end

      if (reset_at >= 0 && nwr == reset_at) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk_1);
        @(negedge clk_1);
        rst_n = 1'b1;
        post_bad = 0;
        for (int j = 0; j < 20; j++) begin
          @(negedge clk_1);
          if (!dma_wen_n && dma_address >= 16'h4828) post_bad++;
          if (!dma_wen_n) nwr++;
        end
        check_val("partial_write_count", 32'(nwr), 32'(reset_at));
        check_val("no_write_after_reset", 32'(post_bad), 32'd0);
        check_val("rdy_after_reset", 32'(cpu_rdy), 32'd1);
        vblank = 1'b1;
        return;
      end

      if (ndone > 0 && k == done_k + 1) begin
        check_val("rdy_after_done",  32'(cpu_rdy),  32'd1);
        check_val("busy_after_done", 32'(dma_busy), 32'd0);
        finished = 1'b1;
        break;
      end
    end

    check_val("finished_in_budget", 32'(finished), 32'd1);
    exp_first = (armed_wait > 1 ? armed_wait : 1) + 1;
    check_val("first_read_cycle", 32'(first_rd), 32'(exp_first));
    check_val("done_cycle",       32'(done_k),   32'(exp_first + 2 * NBYTES));
    check_val("done_pulses",      32'(ndone),    32'd1);
    check_val("read_count",       32'(nreads),   32'(NBYTES));
    check_val("write_count",      32'(nwr),      32'(NBYTES));
    check_val("read_addr_errs",   32'(rd_err),   32'd0);
    check_val("write_errs",       32'(wr_err),   32'd0);
    check_val("stall_cycles",     32'(nstall),   32'(exp_first + 2 * NBYTES));
    check_val("overrun_flag",     32'(dma_overrun), 32'(drop_at >= 0));
    if (armed_wait > 0) check_val("armed_wait_errs", 32'(armed_err), 32'd0);
    vblank = 1'b1;
  endtask

  initial begin
    int busy_seen;
    rst_n       = 1'b0;
    vblank      = 1'b1;
    cpu_address = 16'h0000;
    cpu_data_in = 8'h00;
    cpu_wen_n   = 1'b1;
    for (int a = 0; a < 65536; a++) ram_mem[16'(a)] = 8'($urandom);
    for (int n = 0; n < 256; n++) ram_mem[{8'h02, 8'(n)}] = 8'(n) ^ 8'hA5;

    repeat (3) @(negedge clk_1);
    check_reset_outputs("reset");
    check_val("reset_overrun", 32'(dma_overrun), 32'd0);
    rst_n = 1'b1;

    // Write to a neighbouring address must not arm the engine.
    @(negedge clk_1);
    cpu_address = 16'h4F01;
    cpu_data_in = 8'h02;
    cpu_wen_n   = 1'b0;
    @(negedge clk_1);
    cpu_wen_n   = 1'b1;
    busy_seen = 0;
    repeat (4) begin
      @(negedge clk_1);
      if (dma_busy || !cpu_rdy) busy_seen++;
    end
    check_val("wrong_addr_no_trigger", 32'(busy_seen), 32'd0);

    run_xfer(8'h02, 0,   -1, -1, -1);
    run_xfer(8'h02, 100, -1, -1, -1);
    run_xfer(8'h02, 0,   -1, 50, -1);
    run_xfer(8'($urandom), 0, 10, -1, -1);
    run_xfer(8'($urandom), 0, -1, -1, -1);
    for (int t = 0; t < 3; t++) begin
      run_xfer(8'($urandom), int'($urandom_range(0, 20)), -1,
               int'($urandom_range(3, 400)), -1);
    end
    run_xfer(8'($urandom), 0, -1, -1, 40);
    run_xfer(8'($urandom), 0, -1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
